seg_scan_decoder: RTL
=====================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the 8-digit multiplexed 7-segment scan driver.
- Samples the scanned digit-select and segment buses, filters scan transitions and ghosting, and decodes each segment pattern back to a hex nibble.
- Reassembles the 32-bit display word and pulses a valid flag once every digit has been captured.
- Used in loopback verification and in board-level display snooping.

Parameters:
STABLE_CYCLES, 4, consecutive Clk edges a Sel/DisPlay pair must hold before it is accepted (legal range 2..255).
CNT_W, 8, width of the stability counter; must hold STABLE_CYCLES.

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  synchronous reset, active-high
Sel  input  8  digit select, active-low one-hot; Sel[i]=0 selects digit i (nibble [4i+3:4i])
DisPlay  input  8  segments, active-low; [7]=dp, [6:0]={g,f,e,d,c,b,a}
Data_Out  output  32  last complete decoded word
Data_Valid  output  1  one-cycle pulse when Data_Out updates
Seg_Err  output  1  one-cycle pulse on an accepted sample with an undecodable pattern
Digit_Seen  output  8  digits captured in the current frame

Behaviour:
- Clocking and reset: one clock domain (Clk). Reset is synchronous, active-high.
- Reset values: Data_Out=0, Data_Valid=0, Seg_Err=0, Digit_Seen=0, shadow word=0, stability counter=0, input registers=8'hFF.
- Input stage: Sel and DisPlay are registered every cycle as s_sel and s_seg.
  - If {s_sel,s_seg} equals the previous registered pair, cnt increments and saturates at STABLE_CYCLES.
  - Otherwise cnt=1.
- Accept event: the single cycle in which cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES. There is exactly one accept per hold period; a longer hold causes no re-accept.
- Sel qualification at accept:
  - s_sel must have exactly one zero bit.
  - All-ones (blanking) or multi-zero values are ignored silently: no capture, no error.
- Decode of s_seg[6:0] (dp is ignored):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (hex, bit7 taken as 1).
  - Match: shadow nibble i <= decoded value; Digit_Seen[i] <= 1. A digit already seen is overwritten with the new value.
  - No match: Seg_Err=1 for one cycle; shadow and Digit_Seen are unchanged.
- Frame completion: if an accept makes Digit_Seen all ones (the accepted digit is included), then on the next edge:
  - Data_Out <= shadow including that digit;
  - Data_Valid=1 for one cycle;
  - Digit_Seen <= 0.
  - The shadow is not cleared.
- Latency: the 8th digit's value appears at the pins before edge t; Data_Valid is high in the cycle after edge t+STABLE_CYCLES+1.
- Data_Out is held between frames.
- Reset mid-frame: partial frame discarded, all state returns to reset values, and the next frame starts from scratch.
- Simultaneous events:
  - An accept in the same cycle as a Data_Valid pulse begins the next frame; its Digit_Seen bit survives the clear.
  - Seg_Err and Data_Valid never assert together for the same accept.

Optional Feature:
Macro SEG_DP_CAPTURE_EN.
- Defined:
  - Adds output Dp_Out[7:0], reset 0.
  - The dp bit (~s_seg[7]) is latched per digit on each valid accept.
  - Dp_Out updates together with Data_Out; its bit i is 1 when the dp of digit i is lit.
- Undefined:
  - No Dp_Out port.
  - DisPlay[7] is ignored entirely.

Test Plan:
- Reset, then scan digits 0..7 with Sel=FE,FD,..,7F and patterns for 8,7,6,5,4,3,2,1, each held 10 cycles -> one Data_Valid pulse, Data_Out=32'h12345678, Digit_Seen=0 afterwards.
- Same scan with each digit held only 3 cycles (STABLE_CYCLES=4) -> no Data_Valid, Digit_Seen stays 0.
- Digit 2 driven with DisPlay=8'hFF (undecodable), held 10 cycles -> single Seg_Err pulse, Digit_Seen[2]=0; a later valid full scan gives Data_Valid.
- Sel=8'hFF and Sel=8'hFC inserted between digits for 10 cycles each -> no Seg_Err, no capture, final Data_Out correct.
- Reset asserted after 5 of 8 digits, then a full scan of 32'h0000ABCD -> Data_Out=32'h0000ABCD, with no residue from the aborted frame.
- With SEG_DP_CAPTURE_EN defined, dp lit on digits 0 and 7 -> Dp_Out=8'h81 with Data_Valid.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for an 8-digit multiplexed 7-segment scan bus: filters, decodes, reassembles a 32-bit word.
// Optional macro SEG_DP_CAPTURE_EN adds Dp_Out with per-digit decimal-point capture.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  Sel,
  input  logic [7:0]  DisPlay,
  output logic [31:0] Data_Out,
  output logic        Data_Valid,
  output logic        Seg_Err,
`ifdef SEG_DP_CAPTURE_EN
  output logic [7:0]  Dp_Out,
`endif
  output logic [7:0]  Digit_Seen
);

  localparam logic [CNT_W-1:0] STAB = CNT_W'(STABLE_CYCLES);

  function automatic logic one_zero(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, ~v[i]};
    return (n == 4'd1);
  endfunction

  // Returns {match, nibble}; dp (bit 7) is not part of the pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h03:   r = 5'h1B;
      7'h46:   r = 5'h1C;
      7'h21:   r = 5'h1D;
      7'h06:   r = 5'h1E;
      7'h0E:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [7:0]       sel_q, seg_q, seg_in;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic [31:0]      shadow_q, shadow_d, dout_q, dout_d;
  logic [7:0]       seen_q, seen_d;
  logic             done_q, done_d;
  logic             valid_q, err_q, err_d;
  logic             same, sel_ok, cap;
  logic [4:0]       dec;
`ifdef SEG_DP_CAPTURE_EN
  logic [7:0]       dp_shadow_q, dp_shadow_d, dp_out_q, dp_out_d;

  assign seg_in = DisPlay;
`else
  // dp is forced inactive so it never disturbs the stability filter
  assign seg_in = {DisPlay[7] | 1'b1, DisPlay[6:0]};
`endif

  always_comb begin
    same = ({Sel, seg_in} == {sel_q, seg_q});
    if (!same)              cnt_d = CNT_W'(1);
    else if (cnt_q == STAB) cnt_d = cnt_q;
    else                    cnt_d = cnt_q + 1'b1;
    acc_d = same && (cnt_q == STAB - 1'b1);

    sel_ok = acc_q && one_zero(sel_q);
    dec    = seg_decode(seg_q[6:0]);
    cap    = sel_ok && dec[4];
    err_d  = sel_ok && !dec[4];

    shadow_d = shadow_q;
    for (int i = 0; i < 8; i++)
      if (cap && !sel_q[i]) shadow_d[4*i +: 4] = dec[3:0];

    // A capture coinciding with the frame clear starts the next frame
    seen_d = done_q ? 8'h00 : seen_q;
    if (cap) seen_d = seen_d | ~sel_q;
    done_d = cap && (&seen_d);
    dout_d = done_q ? shadow_q : dout_q;
`ifdef SEG_DP_CAPTURE_EN
    dp_shadow_d = dp_shadow_q;
    for (int i = 0; i < 8; i++)
      if (cap && !sel_q[i]) dp_shadow_d[i] = ~seg_q[7];
    dp_out_d = done_q ? dp_shadow_q : dp_out_q;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sel_q    <= 8'hFF;
      seg_q    <= 8'hFF;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      shadow_q <= '0;
      seen_q   <= '0;
      done_q   <= 1'b0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef SEG_DP_CAPTURE_EN
      dp_shadow_q <= '0;
      dp_out_q    <= '0;
`endif
    end else begin
      sel_q    <= Sel;
      seg_q    <= seg_in;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      seen_q   <= seen_d;
      done_q   <= done_d;
      dout_q   <= dout_d;
      valid_q  <= done_q;
      err_q    <= err_d;
`ifdef SEG_DP_CAPTURE_EN
      dp_shadow_q <= dp_shadow_d;
      dp_out_q    <= dp_out_d;
`endif
    end
  end

  assign Data_Out   = dout_q;
  assign Data_Valid = valid_q;
  assign Seg_Err    = err_q;
  assign Digit_Seen = seen_q;
`ifdef SEG_DP_CAPTURE_EN
  assign Dp_Out     = dp_out_q;
`endif

endmodule
